// File: rtl/register_arbiter_pkg.sv
// rtl/register_arbiter_pkg.sv - shared FSM state type and counter width for register_arbiter
package register_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TXN_W = 16;

endpackage

// File: rtl/register_arbiter_rr_pick.sv
// rtl/register_arbiter_rr_pick.sv - combinational round-robin search starting at ptr, wrapping NREQ-1 -> 0
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index,
  output logic            any
);

  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    // Walk ptr, ptr+1, ... modulo NREQ; the first valid hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!any && valid[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        index     = jj;
      end
    end
  end

endmodule

// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - round-robin arbiter sharing one register slice among NREQ requesters
module register_arbiter
  import register_arbiter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  reg_enable,
  output logic [WIDTH-1:0]      reg_data,
  input  logic [WIDTH-1:0]      reg_outa,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [TXN_W-1:0]      txn_count
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  cur_id;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [WIDTH-1:0] win_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_id),
    .any   (pick_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Accept strobe is the live grant in IDLE so the winner sees it in the same cycle.
  assign req_ready  = (state == IDLE && !reset) ? pick_grant : '0;
  assign reg_enable = (state == LOAD);
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = rsp_valid ? cur_id : '0;
  assign rsp_data   = rsp_valid ? reg_outa : '0;

  // reg_data doubles as the latched request data: loaded at accept, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      reg_data  <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur_id   <= pick_id;
            reg_data <= win_data;
            state    <= LOAD;
          end
        end
        LOAD: state <= RESP;
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rr_ptr    <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
            txn_count <= txn_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_arbiter.sv
// tb/tb_register_arbiter.sv - randomized and directed scoreboard bench for register_arbiter
module tb_register_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  reg_enable;
  logic [WIDTH-1:0]      reg_data;
  logic [WIDTH-1:0]      reg_outa = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [15:0]           txn_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  register_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_enable (reg_enable),
    .reg_data   (reg_data),
    .reg_outa   (reg_outa),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .txn_count  (txn_count)
  );

  // Shared register slice living outside the arbiter.
  always @(posedge clk) if (reg_enable) reg_outa <= reg_data;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   g_idx[$];
  int   g_cyc[$];

  // Reference model: transaction phase 0=idle 1=load 2=resp.
  int               m_phase = 0;
  int               m_ptr = 0;
  int               m_id = 0;
  logic [WIDTH-1:0] m_regdata = '0;
  logic [15:0]      m_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d, input logic rr);
    logic [NREQ-1:0] exp_rdy;
    int win;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    cyc++;
    exp_rdy = '0;
    win = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (win < 0 && v[j]) win = j;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("reg_enable", reg_enable, m_phase == 1);
    chk("reg_data", reg_data, m_regdata);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("txn_count", txn_count, m_count);
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
    case (m_phase)
      0: if (win >= 0) begin
        m_id      = win;
        m_regdata = d[win*WIDTH +: WIDTH];
        exp_q.push_back('{win, m_regdata});
        m_phase   = 1;
      end
      1: m_phase = 2;
      default: if (rr) begin
        m_phase = 0;
        m_ptr   = (m_id + 1) % NREQ;
        m_count = m_count + 16'd1;
      end
    endcase
  endtask

  task automatic apply_reset(input logic in_load);
    @(negedge clk);
    if (in_load) chk("pre_reset_in_load", reg_enable, 1);
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_reg_enable", reg_enable, 0);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_txn_count", txn_count, 0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    m_phase   = 0;
    m_ptr     = 0;
    m_count   = '0;
    m_regdata = '0;
    exp_q.delete();
    g_idx.delete();
    g_cyc.delete();
  endtask

  // Monitor: scoreboard pop on each response handshake, hold checks under backpressure.
  initial begin
    logic             pv, pr;
    logic [IDW-1:0]   pid;
    logic [WIDTH-1:0] pd;
    exp_t             e;
    pv = 1'b0; pr = 1'b0; pid = '0; pd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("rsp_hold_valid", rsp_valid, 1);
          chk("rsp_hold_id", rsp_id, pid);
          chk("rsp_hold_data", rsp_data, pd);
        end
        if (rsp_valid && rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
          end
        end
        pv = rsp_valid; pr = rsp_ready; pid = rsp_id; pd = rsp_data;
      end
    end
  end

  initial begin
    apply_reset(1'b0);

    // All requesters valid: grants 0,1,2,3,0 spaced 3 cycles.
    repeat (15) step(4'b1111, 32'hD4C3B2A1, 1'b1);
    chk("all_grant_count", g_idx.size() >= 5, 1);
    if (g_idx.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("all_grant_order", g_idx[i], i % NREQ);
        if (i > 0) chk("all_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
      end
    end

    // Single requester 2 with 0x5A.
    apply_reset(1'b0);
    step(4'b0100, 32'h005A0000, 1'b1);
    chk("single_ready", req_ready, 4'b0100);
    step(4'b0000, 32'h0, 1'b1);
    chk("single_reg_enable", reg_enable, 1);
    chk("single_reg_data", reg_data, 8'h5A);
    step(4'b0000, 32'h0, 1'b1);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 8'h5A);
    step(4'b0000, 32'h0, 1'b1);
    chk("single_txn_count", txn_count, 1);

    // Backpressure for 5 cycles in RESP.
    apply_reset(1'b0);
    step(4'b0001, 32'h000000C3, 1'b0);
    step(4'b1111, 32'h11223344, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 32'h11223344, 1'b0);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_rsp_data", rsp_data, 8'hC3);
      chk("bp_req_ready", req_ready, 0);
    end
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b0);

    // Reset during LOAD, then 0b1010 must go to requester 1.
    apply_reset(1'b0);
    step(4'b0001, 32'h000000EE, 1'b1);
    apply_reset(1'b1);
    step(4'b1010, 32'h44332211, 1'b1);
    chk("rst_regrant", req_ready, 4'b0010);
    repeat (3) step(4'b0000, 32'h0, 1'b1);

    // Late request from requester 3 during RESP of requester 0.
    apply_reset(1'b0);
    step(4'b0001, 32'h00000077, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b1000, 32'h99000000, 1'b1);
    step(4'b1000, 32'h99000000, 1'b1);
    chk("late_grant", req_ready, 4'b1000);
    repeat (3) step(4'b0000, 32'h0, 1'b1);

    // Counter wrap via a preload of the count.
    @(negedge clk);
    force dut.txn_count = 16'hFFFE;
    #1;
    release dut.txn_count;
    m_count = 16'hFFFE;
    repeat (6) step(4'b0001, 32'h00000001, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    chk("wrap_txn_count", txn_count, 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
    end
    repeat (4) step(4'b0000, 32'h0, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_arbiter.md
REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of requesters and of the shared register slice.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8); IDW = $clog2(NREQ).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, per-requester request.
REQ-006 The block SHALL have port req_data, input, NREQ*WIDTH, per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_ready, output, NREQ, one-hot accept strobe.
REQ-008 The block SHALL have port reg_enable, output, 1, load strobe to the shared register slice.
REQ-009 The block SHALL have port reg_data, output, WIDTH, data to the shared register slice.
REQ-010 The block SHALL have port reg_outa, input, WIDTH, registered output returned by the shared slice.
REQ-011 The block SHALL have port rsp_valid, output, 1, response available.
REQ-012 The block SHALL have port rsp_ready, input, 1, response consumed.
REQ-013 The block SHALL have port rsp_id, output, IDW, index of the requester the response belongs to.
REQ-014 The block SHALL have port rsp_data, output, WIDTH, response data.
REQ-015 The block SHALL have port txn_count, output, 16, count of completed transactions.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and RESP.
REQ-017 In IDLE with any req_valid high, the block SHALL pick the requester round-robin and assert req_ready for that requester only, for exactly that cycle.
- Search starts at index rr_ptr and wraps NREQ-1 -> 0.
- On that edge: latch req_data of the winner and its index; go to LOAD.
REQ-018 In IDLE with no req_valid high, req_ready SHALL be all zero and the state SHALL remain IDLE.
REQ-019 In LOAD, reg_enable SHALL be 1 and reg_data SHALL equal the latched data for exactly one cycle; next state is RESP.
REQ-020 Outside LOAD, reg_enable SHALL be 0 and reg_data SHALL hold its last value.
REQ-021 In RESP, the block SHALL drive rsp_valid=1, rsp_data=reg_outa and rsp_id=the latched index, and SHALL hold them stable until rsp_ready=1.
REQ-022 On the RESP cycle with rsp_ready=1, the block SHALL:
- go to IDLE;
- set rr_ptr = (granted index + 1) mod NREQ;
- increment txn_count, wrapping 0xFFFF -> 0x0000.
REQ-023 Latency SHALL be as follows: accept in cycle T, reg_enable in T+1, rsp_valid in T+2; minimum spacing between accepts is 3 cycles.
REQ-024 req_valid changes during LOAD or RESP SHALL be ignored; a requester dropping req_valid before its grant loses no state and is not granted.
REQ-025 When all requesters are continuously valid, each SHALL be granted once every NREQ transactions (no starvation).
REQ-026 rsp_ready held high before RESP SHALL complete RESP in its first cycle (2-cycle turnaround back to IDLE).

Reset
REQ-027 While reset=1, regardless of clk, the block SHALL be in the following state:
- state=IDLE, rr_ptr=0, req_ready=0, reg_enable=0;
- reg_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, txn_count=0.
REQ-028 Reset asserted in LOAD or RESP SHALL discard the in-flight transaction without a response; after release, the first grant SHALL start the search from index 0.

Structure
REQ-029 A shared package register_arbiter_pkg SHALL hold the state enum (IDLE, LOAD, RESP) and the txn_count width constant (16).
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: grant one-hot, grant index, any).
REQ-031 The shared register slice SHALL be instantiated outside this block; the bench connects it between reg_enable/reg_data and reg_outa.

Verification
REQ-032 The bench SHALL cover the single-requester scenario: req_valid=0b0100 with data 0x5A -> req_ready=0b0100 at T, reg_enable at T+1, rsp_valid at T+2 with rsp_id=2, rsp_data=0x5A, and txn_count=1 after handshake.
REQ-033 The bench SHALL cover the all-requester scenario: req_valid=0b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with accepts spaced 3 cycles apart.
REQ-034 The bench SHALL cover backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable for 5 cycles, and no req_ready asserted.
REQ-035 The bench SHALL cover reset mid-operation: reset pulse during LOAD -> all outputs 0 immediately, no response, and the next grant with req_valid=0b1010 goes to requester 1.
REQ-036 The bench SHALL cover counter wrap: preload via 65536 transactions (or force) -> txn_count goes 0xFFFF -> 0x0000.
REQ-037 The bench SHALL cover late request: req_valid[3] rising during RESP of requester 0 -> requester 3 granted on the first IDLE cycle.
